// File: rtl/pp_result_writer.sv
// Result writer for the 32-lane post-process array: buffers each result vector
// in a small FIFO and streams it out as WORD_W-bit SRAM write beats.
module pp_result_writer #(
   parameter int LANES      = 32,
   parameter int WORD_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [ADDR_W-1:0]                cfg_base_addr,
   input  logic [15:0]                      cfg_num_vec,
   input  logic                             pp_done,
   input  logic [LANES*8-1:0]               pp_result_flat,
   output logic                             mem_wr_en,
   output logic [ADDR_W-1:0]                mem_wr_addr,
   output logic [WORD_W-1:0]                mem_wr_data,
   input  logic                             mem_wr_ready,
   output logic                             busy,
   output logic                             done,
   output logic                             overflow,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);
   localparam int VEC_W = LANES * 8;
   localparam int B     = WORD_W / 8;
   localparam int BEATS = LANES / B;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int LW    = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [15:0]       num_q, num_d, cap_q, cap_d, vec_q, vec_d, drop_q, drop_d;
   logic [BW-1:0]     beat_q, beat_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic              ovf_q, ovf_d;
   logic              en_q, en_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] data_q, data_d;
   logic [VEC_W-1:0]  mem_q [FIFO_DEPTH];
   logic [VEC_W-1:0]  head_d;
   logic              fire, pop, full, push_req, push;

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      num_d    = num_q;
      cap_d    = cap_q;
      vec_d    = vec_q;
      drop_d   = drop_q;
      beat_d   = beat_q;
      ovf_d    = ovf_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;

      fire     = en_q && mem_wr_ready;
      pop      = fire && (beat_q == BW'(BEATS - 1));
      full     = (level_q == LW'(FIFO_DEPTH));
      push_req = (state_q == S_RUN) && pp_done && (cap_q < num_q);
      // A full FIFO still accepts a vector if the head leaves on the same edge.
      push     = push_req && (!full || pop);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d  = cfg_base_addr;
               num_d   = cfg_num_vec;
               ovf_d   = 1'b0;
               cap_d   = '0;
               vec_d   = '0;
               drop_d  = '0;
               beat_d  = '0;
               state_d = (cfg_num_vec == 16'd0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (push_req) begin
               cap_d = cap_q + 16'd1;
               if (!push) begin
                  drop_d = drop_q + 16'd1;
                  ovf_d  = 1'b1;
               end
            end
            if (pop) begin
               beat_d = '0;
               vec_d  = vec_q + 16'd1;
            end else if (fire) begin
               beat_d = beat_q + BW'(1);
            end
            // Written plus dropped covers every capture only once the FIFO has drained.
            if (17'(vec_d) + 17'(drop_d) == 17'(num_q)) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      level_d = level_q + LW'(push) - LW'(pop);

      // Outputs are registered from next-state values so a capture into an empty
      // FIFO shows up on the bus the very next cycle.
      head_d = (push && (wr_ptr_q == rd_ptr_d)) ? pp_result_flat : mem_q[rd_ptr_d];
      en_d   = (state_d == S_RUN) && (level_d != '0);
      addr_d = base_d + ADDR_W'(vec_d) * ADDR_W'(BEATS) + ADDR_W'(beat_d);
      data_d = head_d[beat_d*WORD_W +: WORD_W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         base_q   <= '0;
         num_q    <= '0;
         cap_q    <= '0;
         vec_q    <= '0;
         drop_q   <= '0;
         beat_q   <= '0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         en_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         num_q    <= num_d;
         cap_q    <= cap_d;
         vec_q    <= vec_d;
         drop_q   <= drop_d;
         beat_q   <= beat_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         en_q     <= en_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= pp_result_flat;
   end

   assign mem_wr_en   = en_q;
   assign mem_wr_addr = addr_q;
   assign mem_wr_data = data_q;
   assign busy        = (state_q == S_RUN);
   assign done        = (state_q == S_DONE);
   assign overflow    = ovf_q;
   assign fifo_level  = level_q;
endmodule

// File: tb/tb_pp_result_writer.sv
// Bench for pp_result_writer: job table with hand-derived results, a queue-based
// reference model compared every cycle, reset-abort sequence and random jobs.
module tb_pp_result_writer;
   localparam int LANES = 32, WORD_W = 32, DEPTH = 4, ADDR_W = 16, BEATS = 8;

   logic              clk = 1'b0;
   logic              rst, start, pp_done, mem_wr_ready;
   logic [15:0]       cfg_base_addr, cfg_num_vec;
   logic [255:0]      pp_result_flat;
   logic              mem_wr_en, busy, done, overflow;
   logic [15:0]       mem_wr_addr;
   logic [31:0]       mem_wr_data;
   logic [2:0]        fifo_level;

   always #5 clk = ~clk;

   pp_result_writer #(.LANES(LANES), .WORD_W(WORD_W), .FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_base_addr(cfg_base_addr),
      .cfg_num_vec(cfg_num_vec), .pp_done(pp_done), .pp_result_flat(pp_result_flat),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_wr_ready(mem_wr_ready), .busy(busy), .done(done), .overflow(overflow),
      .fifo_level(fifo_level)
   );

   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: job state plus a queue of buffered vectors.
   bit           m_run = 0, m_donep = 0, m_ovf = 0;
   logic [15:0]  m_base = '0;
   int           m_num = 0, m_cap = 0, m_vec = 0, m_drop = 0, m_beat = 0;
   logic [255:0] m_q[$];
   logic [255:0] m_head;
   bit           m_fire, m_pop, m_push;
   logic [15:0]  addr_log[$];
   logic [31:0]  data_log[$];
   int           done_total = 0;

   always @(negedge clk) begin
      chk("en", mem_wr_en, (m_run && m_q.size() > 0));
      chk("busy", busy, m_run);
      chk("done", done, m_donep);
      chk("overflow", overflow, m_ovf);
      chk("level", fifo_level, m_q.size());
      if (m_run && m_q.size() > 0) begin
         m_head = m_q[0];
         chk("addr", mem_wr_addr, 16'(m_base + m_vec * BEATS + m_beat));
         chk("data", mem_wr_data, m_head[m_beat*32 +: 32]);
      end
      if (done) done_total++;
      if (mem_wr_en && mem_wr_ready && !rst) begin
         addr_log.push_back(mem_wr_addr);
         data_log.push_back(mem_wr_data);
      end
      // Advance the model with the inputs that the coming edge will sample.
      if (rst) begin
         m_run = 0; m_donep = 0; m_ovf = 0; m_q.delete(); m_beat = 0; m_vec = 0;
      end else if (m_donep) begin
         m_donep = 0;
      end else if (!m_run) begin
         if (start) begin
            m_base = cfg_base_addr; m_num = cfg_num_vec; m_ovf = 0;
            m_cap = 0; m_vec = 0; m_beat = 0; m_drop = 0;
            if (m_num == 0) m_donep = 1; else m_run = 1;
         end
      end else begin
         m_fire = (m_q.size() > 0) && mem_wr_ready;
         m_pop  = m_fire && (m_beat == BEATS - 1);
         m_push = 0;
         if (pp_done && m_cap < m_num) begin
            m_cap++;
            if (m_q.size() < DEPTH || m_pop) m_push = 1;
            else begin m_drop++; m_ovf = 1; end
         end
         if (m_fire) m_beat++;
         if (m_pop) begin void'(m_q.pop_front()); m_beat = 0; m_vec++; end
         if (m_push) m_q.push_back(pp_result_flat);
         if (m_vec + m_drop == m_num) begin m_run = 0; m_donep = 1; end
      end
   end

   typedef struct {
      logic [15:0] base;
      int          num, pulses, gap, rmode;
      bit          bstart, tbl;
      int          exp_beats;
      bit          exp_ovf;
      logic [15:0] exp_first_addr, exp_last_addr;
      logic [31:0] exp_first_data;
   } job_t;

   job_t jobs[6];
   bit   tgl = 0, rel = 0;

   function automatic logic [255:0] mkvec(input int k);
      logic [255:0] v;
      for (int i = 0; i < LANES; i++) v[i*8 +: 8] = 8'(i + 1 + k * 'h40);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // rmode: 0 ready high, 1 toggling, 2 held low until released, 3 random
   task automatic drive(input int mode);
      case (mode)
         0: mem_wr_ready = 1'b1;
         1: begin tgl = ~tgl; mem_wr_ready = tgl; end
         2: mem_wr_ready = rel;
         default: mem_wr_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
   endtask

   task automatic run_job(input job_t j, output int idx0);
      int d0, n, nb;
      d0 = done_total; idx0 = addr_log.size(); rel = 0;
      cfg_base_addr = j.base; cfg_num_vec = 16'(j.num); start = 1;
      drive(j.rmode);
      start = 0;
      if (j.num == 0) begin
         chk("zero_done", done, 1);
         chk("zero_en", mem_wr_en, 0);
      end
      for (int p = 0; p < j.pulses; p++) begin
         pp_done = 1;
         pp_result_flat = (j.rmode == 3) ? {8{$urandom}} : mkvec(p);
         drive(j.rmode);
         pp_done = 0;
         if (j.rmode == 2) begin
            chk("ovf_level", fifo_level, (p + 1 < DEPTH) ? p + 1 : DEPTH);
            chk("ovf_flag", overflow, (p >= DEPTH));
         end
         if (j.bstart && p == 0) begin
            start = 1; cfg_base_addr = 16'h7777; cfg_num_vec = 16'd9;
            drive(j.rmode);
            start = 0;
         end
         for (int g = 1; g < j.gap; g++) drive(j.rmode);
      end
      rel = 1;
      for (n = 0; n < 3000 && done_total == d0; n++) drive(j.rmode);
      repeat (3) drive(j.rmode);
      chk("done_once", done_total - d0, 1);
      nb = addr_log.size() - idx0;
      if (j.tbl) begin
         chk("beats", nb, j.exp_beats);
         chk("job_ovf", overflow, j.exp_ovf);
         if (j.exp_beats > 0 && nb == j.exp_beats) begin
            chk("first_addr", addr_log[idx0], j.exp_first_addr);
            chk("first_data", data_log[idx0], j.exp_first_data);
            chk("last_addr", addr_log[idx0 + nb - 1], j.exp_last_addr);
         end
      end else begin
         chk("rnd_beats", nb, BEATS * (j.num - m_drop));
      end
   endtask

   initial begin
      int   idx0, d0, n;
      job_t rj;
      //          base      num pul gap rm bst tbl beats ovf first     last      data
      jobs[0] = '{16'h0100, 2,  2,  10, 0, 0,  1,  16,   0,  16'h0100, 16'h010F, 32'h04030201};
      jobs[1] = '{16'h0200, 3,  3,  3,  1, 0,  1,  24,   0,  16'h0200, 16'h0217, 32'h04030201};
      jobs[2] = '{16'h0300, 6,  6,  1,  2, 0,  1,  32,   1,  16'h0300, 16'h031F, 32'h04030201};
      jobs[3] = '{16'h1234, 0,  0,  1,  0, 0,  1,  0,    0,  16'h0000, 16'h0000, 32'h0};
      jobs[4] = '{16'hFFFC, 1,  1,  1,  0, 0,  1,  8,    0,  16'hFFFC, 16'h0003, 32'h04030201};
      jobs[5] = '{16'h0400, 2,  3,  12, 0, 1,  1,  16,   0,  16'h0400, 16'h040F, 32'h04030201};

      rst = 1; start = 0; pp_done = 0; mem_wr_ready = 0;
      cfg_base_addr = '0; cfg_num_vec = '0; pp_result_flat = '0;
      repeat (3) tick();
      chk("rst_en", mem_wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_addr", mem_wr_addr, 0);
      rst = 0;
      tick();

      pp_done = 1; pp_result_flat = mkvec(3);
      tick(); tick();
      pp_done = 0;
      tick();
      chk("idle_level", fifo_level, 0);
      chk("idle_busy", busy, 0);

      for (int i = 0; i < 6; i++) begin
         run_job(jobs[i], idx0);
         if (i == 0 && addr_log.size() > idx0 + 8) begin
            chk("beat8_data", data_log[idx0 + 8], 32'h44434241);
            chk("beat8_addr", addr_log[idx0 + 8], 16'h0108);
         end
      end

      // Abort a job with reset while its fourth beat is on the bus.
      d0 = done_total; idx0 = addr_log.size();
      cfg_base_addr = 16'h0500; cfg_num_vec = 16'd2; start = 1;
      drive(0);
      start = 0;
      pp_done = 1; pp_result_flat = mkvec(7);
      drive(0);
      pp_done = 0;
      for (n = 0; n < 50 && addr_log.size() - idx0 < 3; n++) drive(0);
      chk("rst_mid_reach", addr_log.size() - idx0, 3);
      chk("rst_mid_beat4", mem_wr_addr, 16'h0503);
      rst = 1;
      drive(0);
      rst = 0;
      chk("rst_mid_en", mem_wr_en, 0);
      chk("rst_mid_level", fifo_level, 0);
      chk("rst_mid_busy", busy, 0);
      repeat (6) drive(0);
      chk("rst_mid_nodone", done_total - d0, 0);
      chk("rst_mid_nobeats", addr_log.size() - idx0, 3);
      run_job(jobs[0], idx0);

      for (int r = 0; r < 8; r++) begin
         rj = '{16'($urandom), 0, 0, 0, 3, 0, 0, 0, 0, 16'h0, 16'h0, 32'h0};
         rj.num    = $urandom_range(1, 5);
         rj.pulses = rj.num + $urandom_range(0, 1);
         rj.gap    = $urandom_range(1, 12);
         run_job(rj, idx0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
